// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point radix-2 SDF FFT pipeline: sizes,
// complex sample type, read-FSM states and the bit-reversal helper.
package fft_pkg;

  localparam int N      = 32;
  localparam int LOG2N  = 5;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = {LOG2N{1'b0}};
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = a[LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Valid-only complex sample stream in (bit-reversed) and out (natural order)
// of the FFT output reorder buffer.
interface fft_out_reorder_if
  import fft_pkg::*;
#(
  parameter int LOG2N  = fft_pkg::LOG2N,
  parameter int DATA_W = fft_pkg::DATA_W
) ();

  logic              valid_i;
  logic [DATA_W-1:0] data_in_r;
  logic [DATA_W-1:0] data_in_i;
  logic              valid_o;
  logic              sop_o;
  logic [LOG2N-1:0]  index_o;
  logic [DATA_W-1:0] data_out_r;
  logic [DATA_W-1:0] data_out_i;

  modport slave (
    input  valid_i, data_in_r, data_in_i,
    output valid_o, sop_o, index_o, data_out_r, data_out_i
  );

  modport master (
    output valid_i, data_in_r, data_in_i,
    input  valid_o, sop_o, index_o, data_out_r, data_out_i
  );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two banks of N complex samples: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int N      = fft_pkg::N,
  parameter int LOG2N  = fft_pkg::LOG2N,
  parameter int DATA_W = fft_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic                wr_bank_i,
  input  logic [LOG2N-1:0]    wr_addr_i,
  input  logic [2*DATA_W-1:0] wr_data_i,
  input  logic                rd_bank_i,
  input  logic [LOG2N-1:0]    rd_addr_i,
  output logic [2*DATA_W-1:0] rd_data_o
);

  logic [2*DATA_W-1:0] mem_q [2][N];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];

endmodule

// File: rtl/fft_out_reorder.sv
// Output reorder buffer: writes each bit-reversed frame into one ping-pong
// bank and streams the other bank out as a contiguous natural-order burst.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int N      = fft_pkg::N,
  parameter int LOG2N  = fft_pkg::LOG2N,
  parameter int DATA_W = fft_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  fft_out_reorder_if.slave  bus
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ZERO_IDX = {LOG2N{1'b0}};

  logic [LOG2N-1:0]    wr_cnt_q, wr_cnt_d;
  logic                wr_bank_q, wr_bank_d;
  logic [1:0]          full_q, full_d;
  logic [LOG2N-1:0]    rd_cnt_q, rd_cnt_d;
  logic                rd_bank_q, rd_bank_d;
  rd_state_e           state_q, state_d;
  logic                valid_q, valid_d;
  logic                sop_q, sop_d;
  logic [LOG2N-1:0]    index_q, index_d;
  logic [DATA_W-1:0]   re_q, re_d;
  logic [DATA_W-1:0]   im_q, im_d;

  logic [LOG2N-1:0]    wr_addr_s;
  logic [2*DATA_W-1:0] wr_data_s;
  logic [2*DATA_W-1:0] rd_data_s;
  logic                wr_last_s;
  logic                rd_active_s;
  logic                rd_last_s;

  assign wr_addr_s   = bitrev(wr_cnt_q);
  assign wr_data_s   = {bus.data_in_r, bus.data_in_i};
  assign wr_last_s   = bus.valid_i && (wr_cnt_q == LAST_IDX);
  assign rd_active_s = (state_q == RD_READ);
  assign rd_last_s   = rd_active_s && (rd_cnt_q == LAST_IDX);

  fft_pingpong_ram #(
    .N      (N),
    .LOG2N  (LOG2N),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk       (clk),
    .we_i      (bus.valid_i),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_addr_s),
    .wr_data_i (wr_data_s),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_cnt_q),
    .rd_data_o (rd_data_s)
  );

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (bus.valid_i) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (wr_last_s) begin
      wr_bank_d = ~wr_bank_q;
    end else begin
      wr_bank_d = wr_bank_q;
    end
  end

  // Reader and writer never finish the same bank on the same edge, so set/clear cannot collide.
  always_comb begin
    full_d    = full_q;
    full_d[0] = (full_q[0] & ~(rd_last_s & ~rd_bank_q)) | (wr_last_s & ~wr_bank_q);
    full_d[1] = (full_q[1] & ~(rd_last_s &  rd_bank_q)) | (wr_last_s &  wr_bank_q);
  end

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    case (state_q)
      RD_IDLE: begin
        rd_cnt_d = ZERO_IDX;
        if (full_q[rd_bank_q]) begin
          state_d = RD_READ;
        end else begin
          state_d = RD_IDLE;
        end
      end
      RD_READ: begin
        rd_cnt_d = rd_cnt_q + LOG2N'(1);
        if (rd_last_s) begin
          rd_bank_d = ~rd_bank_q;
          state_d   = full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
        end else begin
          state_d = RD_READ;
        end
      end
      default: begin
        state_d  = RD_IDLE;
        rd_cnt_d = ZERO_IDX;
      end
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    sop_d   = 1'b0;
    index_d = index_q;
    re_d    = re_q;
    im_d    = im_q;
    if (rd_active_s) begin
      valid_d      = 1'b1;
      sop_d        = (rd_cnt_q == ZERO_IDX);
      index_d      = rd_cnt_q;
      {re_d, im_d} = rd_data_s;
    end else begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q  <= ZERO_IDX;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      rd_cnt_q  <= ZERO_IDX;
      rd_bank_q <= 1'b0;
      state_q   <= RD_IDLE;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      index_q   <= ZERO_IDX;
      re_q      <= {DATA_W{1'b0}};
      im_q      <= {DATA_W{1'b0}};
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      index_q   <= index_d;
      re_q      <= re_d;
      im_q      <= im_d;
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.sop_o      = sop_q;
  assign bus.index_o    = index_q;
  assign bus.data_out_r = re_q;
  assign bus.data_out_i = im_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: table of per-sample inputs and
// expected natural-order outputs, plus reset and back-to-back sequences.
module tb_fft_out_reorder;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_out_reorder_if #(.LOG2N(LOG2N), .DATA_W(DATA_W)) bus ();

  fft_out_reorder #(
    .N      (N),
    .LOG2N  (LOG2N),
    .DATA_W (DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic [4:0]  exp_idx;
    logic [15:0] exp_re;
    logic [15:0] exp_im;
    logic        exp_sop;
  } vec_t;

  // 5-bit bit reversal of 0..31, worked out by hand
  localparam int BR [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                             1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

  vec_t tab [32];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_in_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frames(input int nfr, input int gap, input int base);
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < 32; k++) begin
        bus.valid_i   = 1'b1;
        bus.data_in_r = tab[k].in_re + 16'(base + f * 64);
        bus.data_in_i = tab[k].in_im + 16'(base + f * 64);
        tick();
        if (f == 0 && k == 31) last_in_cyc = cyc;
        if (gap != 0) begin
          bus.valid_i = 1'b0;
          tick();
        end
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic check_frames(input int nfr, input int base, input string tag);
    int waited;
    waited = 0;
    while (bus.valid_o !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (bus.valid_o !== 1'b1) begin
      chk({tag, " start timeout"}, 32'(bus.valid_o), 32'd1);
      return;
    end
    chk({tag, " latency"}, 32'(cyc - last_in_cyc), 32'd2);
    for (int f = 0; f < nfr; f++) begin
      for (int j = 0; j < 32; j++) begin
        if (f != 0 || j != 0) tick();
        chk({tag, " valid"}, 32'(bus.valid_o), 32'd1);
        chk({tag, " index"}, 32'(bus.index_o), 32'(tab[j].exp_idx));
        chk({tag, " sop"},   32'(bus.sop_o),   32'(tab[j].exp_sop));
        chk({tag, " re"},    32'(bus.data_out_r), 32'(16'(tab[j].exp_re + 16'(base + f * 64))));
        chk({tag, " im"},    32'(bus.data_out_i), 32'(16'(tab[j].exp_im + 16'(base + f * 64))));
      end
    end
    tick();
    chk({tag, " burst end"}, 32'(bus.valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;

    for (int k = 0; k < 32; k++) begin
      tab[k].in_re   = 16'(k);
      tab[k].in_im   = 16'(31 - k);
      tab[k].exp_idx = 5'(k);
      tab[k].exp_re  = 16'(BR[k]);
      tab[k].exp_im  = 16'(31 - BR[k]);
      tab[k].exp_sop = (k == 0);
    end

    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.data_in_r = 16'd0;
    bus.data_in_i = 16'd0;
    tick();
    tick();
    chk("reset valid", 32'(bus.valid_o), 32'd0);
    chk("reset sop",   32'(bus.sop_o), 32'd0);
    chk("reset index", 32'(bus.index_o), 32'd0);
    chk("reset re",    32'(bus.data_out_r), 32'd0);
    chk("reset im",    32'(bus.data_out_i), 32'd0);
    rst = 1'b0;

    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.valid_o !== 1'b0) stray++;
    end
    chk("idle no valid", 32'(stray), 32'd0);

    fork
      drive_frames(1, 0, 0);
      check_frames(1, 0, "single");
    join

    fork
      drive_frames(3, 0, 256);
      check_frames(3, 256, "cont3");
    join

    fork
      drive_frames(1, 1, 512);
      check_frames(1, 512, "alt");
    join

    // Full frame A plus 12 samples of frame B, then reset while X[10] of A is out
    for (int k = 0; k < 44; k++) begin
      bus.valid_i   = 1'b1;
      bus.data_in_r = tab[k % 32].in_re + 16'(k < 32 ? 1024 : 2048);
      bus.data_in_i = tab[k % 32].in_im + 16'(k < 32 ? 1024 : 2048);
      tick();
    end
    bus.valid_i = 1'b0;
    chk("pre-reset valid", 32'(bus.valid_o), 32'd1);
    chk("pre-reset index", 32'(bus.index_o), 32'd10);
    chk("pre-reset re",    32'(bus.data_out_r), 32'(16'(BR[10] + 1024)));
    rst = 1'b1;
    #1;
    chk("async rst valid", 32'(bus.valid_o), 32'd0);
    chk("async rst sop",   32'(bus.sop_o), 32'd0);
    chk("async rst index", 32'(bus.index_o), 32'd0);
    chk("async rst re",    32'(bus.data_out_r), 32'd0);
    chk("async rst im",    32'(bus.data_out_i), 32'd0);
    tick();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.valid_o !== 1'b0) stray++;
    end
    chk("post-reset no residue", 32'(stray), 32'd0);

    fork
      drive_frames(1, 0, 768);
      check_frames(1, 768, "after-reset");
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder buffer for the 32-point radix-2 SDF FFT pipeline. It receives the bit-reversed, valid-qualified complex sample stream leaving the last butterfly stage and emits each 32-point frame in natural frequency order (X[0]..X[31]) as a contiguous 32-cycle burst. A ping-pong pair of 32-entry banks lets frame n+1 be written while frame n is read, so continuous input is sustained with no stalls. It sits between the final FFT stage and the result sink, using the same valid-only (no backpressure) stream protocol.

## Interface

- N, 32, points per frame (power of two)
- LOG2N, 5, log2(N); width of index counters
- DATA_W, 16, width of each real/imag component (final-stage output width)

- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous active-high reset
- valid_i  input  1  sample on data_in_r/i is valid this cycle
- data_in_r  input  DATA_W  real part, bit-reversed frame order
- data_in_i  input  DATA_W  imaginary part, bit-reversed frame order
- valid_o  output  1  data_out_r/i holds a valid natural-order sample
- sop_o  output  1  high with X[0] of each output frame
- index_o  output  LOG2N  natural frequency index of current output
- data_out_r  output  DATA_W  real part, natural order
- data_out_i  output  DATA_W  imaginary part, natural order

## Operation

- The clock is clk; reset is rst, asynchronous and active-high.
- Write side: wr_cnt (LOG2N bits) counts accepted samples; wr_bank selects bank. On valid_i: mem[wr_bank][bitrev(wr_cnt)] <= {data_in_r, data_in_i}; wr_cnt++. When wr_cnt wraps 31->0: full[wr_bank] <= 1, wr_bank toggles.
- valid_i low mid-frame: wr_cnt holds; no write. Gaps of any length are allowed.
- Read FSM, states IDLE and READ. IDLE -> READ when full[rd_bank] (including a flag set this same edge is NOT visible; see Timing). In READ, rd_cnt steps 0..31, one per cycle, unconditionally. At rd_cnt=31: full[rd_bank] <= 0, rd_bank toggles; go to READ again if full[other bank] else IDLE.
- Output registers load mem[rd_bank][rd_cnt] (asynchronous read of register array), index_o <= rd_cnt, sop_o <= (rd_cnt==0), valid_o <= 1 in READ; otherwise valid_o <= 0, sop_o <= 0, data/index hold.
- Overflow cannot occur: input rate <= 1 sample/cycle and read drains 32 samples in 32 cycles; no error flag.
- Reset values: valid_o=0, sop_o=0, index_o=0, data_out_r=0, data_out_i=0; wr_cnt=rd_cnt=0, wr_bank=rd_bank=0, full=2'b00, FSM=IDLE. Memory contents not reset.
- Reset mid-frame or mid-burst: partial frame discarded, outputs drop to reset values immediately (asynchronous); next accepted sample is index 0 of a new frame.

## Timing

- Latency: sample 31 accepted at edge t sets full at t; FSM enters READ at t+1; valid_o/X[0] visible after edge t+2 (two cycles after last input edge). 
- Burst: valid_o high for exactly 32 consecutive cycles per frame, index_o 0..31.
- Continuous input: frame n in at cycles c..c+31, out at c+33..c+64, concurrent with frame n+1 writes; successive bursts are back-to-back with no idle cycle.
- Simultaneous read-finish and other-bank-full on same edge: next burst starts on the following cycle without gap.

## Structure

- Shared package fft_pkg: N, LOG2N, DATA_W defaults, complex sample struct, function bitrev(LOG2N-bit) — reused by the stage modules and benches.
- One sub-module: fft_pingpong_ram — 2 x N x 2*DATA_W register file, one synchronous write port (bank, addr, data, we), one asynchronous read port (bank, addr).
- Top holds write counter, full flags, read FSM and output registers.

## Test plan

- Reset: assert rst mid-run -> all outputs 0 immediately, valid_o stays 0 with no input.
- Single frame, data_in_r=k, data_in_i=31-k for sample k -> 32-cycle burst, output j has data_out_r=bitrev(j) (0,16,8,24,4,...), data_out_i=31-bitrev(j); valid_o first high two cycles after sample 31; sop_o only at j=0.
- Three frames continuous (96 valid cycles) -> 96 consecutive valid_o cycles, no gaps, each frame correctly reordered, index_o wraps 31->0 with sop_o.
- valid_i every other cycle for one frame -> identical output values to scenario 2, output still a contiguous 32-cycle burst.
- Reset at output index 10, then fresh frame -> no residual outputs; new frame reordered correctly starting from bank 0.
- Frame completes on same edge rd_cnt=31 -> next burst starts next cycle, index_o 31 followed directly by 0.
